// File: rtl/fdiv_issue_ctrl_if.sv
// Handshake and divider-side bus for the divider issue controller.
// slave is the controller's view; master is the operand source, divider and result consumer.
interface fdiv_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] div_DD;
  logic [31:0] div_DS;
  logic        div_control;
  logic [31:0] div_out;
  logic        div_exception;
  logic        div_zeroDiv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_exception;
  logic        out_zeroDiv;
  logic        busy;
  logic [15:0] op_count;
  logic [7:0]  zdiv_count;

  modport slave (
    input  in_valid, in_a, in_b, div_out, div_exception, div_zeroDiv, out_ready,
    output in_ready, div_DD, div_DS, div_control, out_valid, out_result,
           out_exception, out_zeroDiv, busy, op_count, zdiv_count
  );

  modport master (
    output in_valid, in_a, in_b, div_out, div_exception, div_zeroDiv, out_ready,
    input  in_ready, div_DD, div_DS, div_control, out_valid, out_result,
           out_exception, out_zeroDiv, busy, op_count, zdiv_count
  );
endinterface

// File: rtl/fdiv_issue_ctrl.sv
// Issue sequencer for the 32-bit FP divider: latch operands, pulse start, wait a
// fixed settle time, then capture the divider outputs into a held result register.
//
// state | meaning
// IDLE  | ready for an operand pair; div_DD/div_DS hold the last operands
// PULSE | div_control high for CTRL_WIDTH cycles
// WAIT  | div_control low, LATENCY-cycle settle countdown
// CAPT  | sample divider outputs once the result register is free
module fdiv_issue_ctrl #(
  parameter int LATENCY    = 100,
  parameter int CTRL_WIDTH = 1
) (
  input logic             clk,
  input logic             reset,
  fdiv_issue_ctrl_if.slave io
);

  localparam int MAXC  = (LATENCY > CTRL_WIDTH) ? LATENCY : CTRL_WIDTH;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(CTRL_WIDTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, CAPT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             in_ready;
  logic             accept;
  logic             load;

  logic [31:0] div_dd_q, div_ds_q;
  logic        div_control_q;
  logic        busy_q;
  logic        out_valid_q;
  logic [31:0] out_result_q;
  logic        out_exception_q;
  logic        out_zerodiv_q;
  logic [15:0] op_count_q;
  logic [7:0]  zdiv_count_q;

  assign in_ready = (state == IDLE) && !reset;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (io.in_valid && in_ready) begin
          accept  = 1'b1;
          cnt_n   = PULSE_LOAD;
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          cnt_n   = WAIT_LOAD;
          state_n = WAIT;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = CAPT;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      CAPT: begin
        // a result still waiting for its consumer blocks the capture
        if (!out_valid_q || io.out_ready) begin
          load    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_dd_q        <= '0;
      div_ds_q        <= '0;
      div_control_q   <= 1'b0;
      busy_q          <= 1'b0;
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_exception_q <= 1'b0;
      out_zerodiv_q   <= 1'b0;
      op_count_q      <= '0;
      zdiv_count_q    <= '0;
    end else begin
      div_control_q <= (state_n == PULSE);
      busy_q        <= (state_n != IDLE);
      if (accept) begin
        div_dd_q <= io.in_a;
        div_ds_q <= io.in_b;
      end
      if (load) begin
        out_valid_q     <= 1'b1;
        out_result_q    <= io.div_out;
        out_exception_q <= io.div_exception;
        out_zerodiv_q   <= io.div_zeroDiv;
        op_count_q      <= op_count_q + 16'd1;
        if (io.div_zeroDiv && (zdiv_count_q != 8'hFF)) begin
          zdiv_count_q <= zdiv_count_q + 8'd1;
        end
      end else if (out_valid_q && io.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign io.in_ready      = in_ready;
  assign io.div_DD        = div_dd_q;
  assign io.div_DS        = div_ds_q;
  assign io.div_control   = div_control_q;
  assign io.busy          = busy_q;
  assign io.out_valid     = out_valid_q;
  assign io.out_result    = out_result_q;
  assign io.out_exception = out_exception_q;
  assign io.out_zeroDiv   = out_zerodiv_q;
  assign io.op_count      = op_count_q;
  assign io.zdiv_count    = zdiv_count_q;

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Bench for fdiv_issue_ctrl: three parameterisations driven by a randomising fake divider,
// with expected timing, captured values and counters derived from the issue rules.
module tb_fdiv_issue_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fdiv_issue_ctrl_if if0 ();
  fdiv_issue_ctrl_if if1 ();
  fdiv_issue_ctrl_if if2 ();

  fdiv_issue_ctrl #(.LATENCY(100), .CTRL_WIDTH(1)) dut0 (.clk(clk), .reset(reset), .io(if0.slave));
  fdiv_issue_ctrl #(.LATENCY(4),   .CTRL_WIDTH(1)) dut1 (.clk(clk), .reset(reset), .io(if1.slave));
  fdiv_issue_ctrl #(.LATENCY(1),   .CTRL_WIDTH(3)) dut2 (.clk(clk), .reset(reset), .io(if2.slave));

  virtual fdiv_issue_ctrl_if vif;

  int          cur, cw, lat, cyc;
  int          nrun, nfail;
  logic [31:0] drv_out;
  logic        drv_exc, cur_zd;
  logic [15:0] op_m [3];
  logic [7:0]  zd_m [3];

  task automatic sel(input int i);
    cur = i;
    case (i)
      0:       begin vif = if0; cw = 1; lat = 100; end
      1:       begin vif = if1; cw = 1; lat = 4;   end
      default: begin vif = if2; cw = 3; lat = 1;   end
    endcase
  endtask

  // fake divider: fresh output word and exception bit every cycle
  task automatic step();
    vif.div_out       = $urandom;
    vif.div_exception = 1'($urandom);
    vif.div_zeroDiv   = cur_zd;
    drv_out = vif.div_out;
    drv_exc = vif.div_exception;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_load(input logic zd);
    op_m[cur] = op_m[cur] + 16'd1;
    if (zd && zd_m[cur] != 8'd255) zd_m[cur] = zd_m[cur] + 8'd1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      op_m[i] = '0;
      zd_m[i] = '0;
    end
  endtask

  task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b, output int acc);
    int n;
    cur_zd = (b[30:0] == 31'd0);
    vif.in_a = a;
    vif.in_b = b;
    vif.in_valid = 1'b1;
    n = 0;
    while (vif.in_ready !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      nrun++; nfail++;
      $display("FAIL %s accept_timeout: in_ready=%b after %0d cycles, required 1", nm, vif.in_ready, n);
    end
    step();
    acc = cyc;
    vif.in_valid = 1'b0;
    nrun++;
    if (vif.div_DD !== a || vif.div_DS !== b) begin
      nfail++;
      $display("FAIL %s operands: DD=%h DS=%h, required %h %h", nm, vif.div_DD, vif.div_DS, a, b);
    end
  endtask

  // one complete operation with the consumer always ready, timing checked cycle by cycle
  task automatic run_check(input string nm, input logic [31:0] a, input logic [31:0] b, output int acc);
    int t, hi, bc, bb, bv, br;
    vif.out_ready = 1'b1;
    issue(nm, a, b, acc);
    t = cw + lat + 1;
    hi = 0; bc = -1; bb = -1; bv = -1; br = -1;
    for (int j = 0; j <= t; j++) begin
      if (vif.div_control === 1'b1) hi++;
      if (vif.div_control !== (j < cw)  && bc < 0) bc = j;
      if (vif.busy        !== (j < t)   && bb < 0) bb = j;
      if (vif.out_valid   !== (j == t)  && bv < 0) bv = j;
      if (vif.in_ready    !== (j == t)  && br < 0) br = j;
      if (j < t) step();
    end
    model_load(cur_zd);
    nrun++;
    if (bc >= 0 || hi != cw) begin
      nfail++;
      $display("FAIL %s div_control: high %0d cycles, first wrong at +%0d, required %0d cycles", nm, hi, bc, cw);
    end
    nrun++;
    if (bb >= 0) begin
      nfail++;
      $display("FAIL %s busy: wrong at +%0d, required high +0..+%0d", nm, bb, t - 1);
    end
    nrun++;
    if (bv >= 0) begin
      nfail++;
      $display("FAIL %s out_valid: wrong at +%0d, required rise at +%0d", nm, bv, t);
    end
    nrun++;
    if (br >= 0) begin
      nfail++;
      $display("FAIL %s in_ready: wrong at +%0d, required high again at +%0d", nm, br, t);
    end
    nrun++;
    if (vif.out_result !== drv_out || vif.out_exception !== drv_exc || vif.out_zeroDiv !== cur_zd) begin
      nfail++;
      $display("FAIL %s result: %h/%b/%b, required %h/%b/%b", nm, vif.out_result, vif.out_exception,
               vif.out_zeroDiv, drv_out, drv_exc, cur_zd);
    end
    nrun++;
    if (vif.op_count !== op_m[cur] || vif.zdiv_count !== zd_m[cur]) begin
      nfail++;
      $display("FAIL %s counters: op=%0d zdiv=%0d, required %0d %0d", nm, vif.op_count, vif.zdiv_count,
               op_m[cur], zd_m[cur]);
    end
  endtask

  task automatic reset_mid();
    #3 reset = 1'b1;
    #1;
  endtask

  task automatic reset_release();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel(i);
      vif.in_valid = 1'b0; vif.in_a = '0; vif.in_b = '0; vif.out_ready = 1'b1;
      vif.div_out = '0; vif.div_exception = 1'b0; vif.div_zeroDiv = 1'b0;
    end
    model_clear();
    cur_zd = 1'b0;
    #23;
    sel(0);
    nrun++;
    if (vif.in_ready !== 1'b0 || vif.busy !== 1'b0 || vif.out_valid !== 1'b0 || vif.div_control !== 1'b0) begin
      nfail++;
      $display("FAIL reset_flags: rdy=%b busy=%b ov=%b ctrl=%b, required all 0", vif.in_ready, vif.busy,
               vif.out_valid, vif.div_control);
    end
    nrun++;
    if (vif.div_DD !== 32'd0 || vif.out_result !== 32'd0 || vif.op_count !== 16'd0 || vif.zdiv_count !== 8'd0) begin
      nfail++;
      $display("FAIL reset_regs: DD=%h res=%h op=%0d zd=%0d, required zeros", vif.div_DD, vif.out_result,
               vif.op_count, vif.zdiv_count);
    end
    reset_release();
    nrun++;
    if (vif.in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", vif.in_ready);
    end
  endtask

  task automatic test_basic();
    int acc;
    sel(0);
    run_check("basic", 32'h4016EB85, 32'h3F9E04F3, acc);
    nrun++;
    if (vif.op_count !== 16'd1) begin
      nfail++;
      $display("FAIL basic_opcount: %0d, required 1", vif.op_count);
    end
  endtask

  task automatic test_div_zero();
    int acc;
    sel(0);
    run_check("divzero", 32'h4145D3A7, 32'h00000000, acc);
    nrun++;
    if (vif.out_zeroDiv !== 1'b1 || vif.zdiv_count !== 8'd1) begin
      nfail++;
      $display("FAIL divzero_flag: zeroDiv=%b zdiv=%0d, required 1 1", vif.out_zeroDiv, vif.zdiv_count);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [31:0] r1, r2;
    logic e2;
    sel(1);
    vif.out_ready = 1'b0;
    issue("bp1", 32'hC2311EB8, 32'h40503F16, acc);
    for (int j = 0; j < cw + lat + 1; j++) step();
    r1 = drv_out;
    model_load(1'b0);
    nrun++;
    if (vif.out_valid !== 1'b1 || vif.out_result !== r1) begin
      nfail++;
      $display("FAIL bp_first: ov=%b res=%h, required 1 %h", vif.out_valid, vif.out_result, r1);
    end
    issue("bp2", 32'h00000000, 32'h40AAF5C3, acc);
    for (int j = 0; j < cw + lat + 6; j++) step();
    nrun++;
    if (vif.out_valid !== 1'b1 || vif.out_result !== r1 || vif.in_ready !== 1'b0 || vif.busy !== 1'b1) begin
      nfail++;
      $display("FAIL bp_stall: ov=%b res=%h rdy=%b busy=%b, required 1 %h 0 1", vif.out_valid,
               vif.out_result, vif.in_ready, vif.busy, r1);
    end
    nrun++;
    if (vif.op_count !== op_m[cur]) begin
      nfail++;
      $display("FAIL bp_stall_count: op=%0d, required %0d", vif.op_count, op_m[cur]);
    end
    vif.out_ready = 1'b1;
    step();
    r2 = drv_out;
    e2 = drv_exc;
    vif.out_ready = 1'b0;
    model_load(1'b0);
    nrun++;
    if (vif.out_valid !== 1'b1 || vif.out_result !== r2 || vif.out_exception !== e2 || vif.in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL bp_swap: ov=%b res=%h exc=%b rdy=%b, required 1 %h %b 1", vif.out_valid, vif.out_result,
               vif.out_exception, vif.in_ready, r2, e2);
    end
    nrun++;
    if (vif.op_count !== op_m[cur]) begin
      nfail++;
      $display("FAIL bp_swap_count: op=%0d, required %0d", vif.op_count, op_m[cur]);
    end
    step();
    nrun++;
    if (vif.out_valid !== 1'b1 || vif.out_result !== r2) begin
      nfail++;
      $display("FAIL bp_hold: ov=%b res=%h, required 1 %h", vif.out_valid, vif.out_result, r2);
    end
    vif.out_ready = 1'b1;
    step();
    nrun++;
    if (vif.out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL bp_drain: ov=%b, required 0", vif.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    sel(2);
    issue("rst_pulse", 32'h3F800000, 32'h40000000, acc);
    reset_mid();
    nrun++;
    if (vif.div_control !== 1'b0 || vif.busy !== 1'b0) begin
      nfail++;
      $display("FAIL rst_pulse_drop: ctrl=%b busy=%b, required 0 0", vif.div_control, vif.busy);
    end
    reset_release();
    sel(0);
    run_check("rst_pre", 32'h40490FDB, 32'h402DF854, acc);
    vif.out_ready = 1'b0;
    issue("rst_wait", 32'h3F800000, 32'h3F800000, acc);
    for (int j = 0; j < 20; j++) step();
    nrun++;
    if (vif.busy !== 1'b1 || vif.out_valid !== 1'b1 || vif.op_count !== 16'd1) begin
      nfail++;
      $display("FAIL rst_pre_state: busy=%b ov=%b op=%0d, required 1 1 1", vif.busy, vif.out_valid, vif.op_count);
    end
    reset_mid();
    nrun++;
    if (vif.div_control !== 1'b0 || vif.out_valid !== 1'b0 || vif.op_count !== 16'd0 ||
        vif.busy !== 1'b0 || vif.in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL rst_wait_drop: ctrl=%b ov=%b op=%0d busy=%b rdy=%b, required 0 0 0 0 0", vif.div_control,
               vif.out_valid, vif.op_count, vif.busy, vif.in_ready);
    end
    reset_release();
    nrun++;
    if (vif.in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL rst_recover_ready: in_ready=%b, required 1", vif.in_ready);
    end
    run_check("rst_recover", 32'h7F800000, 32'h7F800000, acc);
  endtask

  task automatic test_back_to_back();
    int a1, a2;
    sel(2);
    run_check("b2b_1", 32'hFFC00000, 32'hFFC00000, a1);
    run_check("b2b_2", 32'hFFC00000, 32'hFFC00000, a2);
    nrun++;
    if (a2 - a1 != 6) begin
      nfail++;
      $display("FAIL b2b_interval: %0d cycles, required 6", a2 - a1);
    end
  endtask

  task automatic test_zdiv_saturation();
    int acc;
    logic [31:0] b;
    sel(2);
    for (int i = 0; i < 258; i++) begin
      b = ($urandom_range(0, 1) == 0) ? 32'h00000000 : 32'h80000000;
      run_check("zdiv_sat", $urandom, b, acc);
    end
    nrun++;
    if (vif.zdiv_count !== 8'd255) begin
      nfail++;
      $display("FAIL zdiv_saturate: %0d, required 255", vif.zdiv_count);
    end
  endtask

  task automatic test_random();
    int acc, gap;
    logic [31:0] a, b;
    sel(1);
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? {1'($urandom), 31'd0} : $urandom;
      run_check("random", a, b, acc);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    nrun = 0; nfail = 0; cyc = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_zdiv_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
